// File: rtl/plic_reg_array.sv
// Parametrised PLIC register file: priorities, multi-word enables, thresholds, claim/complete.
// Define PLIC_TRIG_CFG_EN to add the read/write per-source trigger-type bank at 0x003000.
package plic_pkg;
    localparam int XLEN                  = 32;
    localparam int PLIC_REG_OFFSET_WIDTH = 22;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] w_data;
        logic            w_en;
        logic            req;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [XLEN-1:0] r_data;
        logic            ack;
    } type_peri2dbus_s;
endpackage

module plic_reg_array
    import plic_pkg::*;
#(
    parameter int  PLIC_SOURCE_COUNT = 31,
    parameter int  PLIC_TARGET_COUNT = 2,
    parameter int  PLIC_PRIO_WIDTH   = 3,
    localparam int SRC_W             = $clog2(PLIC_SOURCE_COUNT + 1),
    localparam int IE_WORDS          = (PLIC_SOURCE_COUNT + 32) / 32
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  type_dbus2peri_s                                    dbus2plic_i,
    output type_peri2dbus_s                                    plic2dbus_o,
    input  logic                                               plic_sel_i,
    input  logic [PLIC_SOURCE_COUNT-1:0]                       irq_pending_i,
    input  logic [PLIC_TARGET_COUNT-1:0][SRC_W-1:0]            claim_idx_i,
    output logic [PLIC_SOURCE_COUNT-1:0][PLIC_PRIO_WIDTH-1:0]  regs_prio_o,
    output logic [PLIC_TARGET_COUNT-1:0][PLIC_SOURCE_COUNT-1:0] regs_ie_o,
    output logic [PLIC_TARGET_COUNT-1:0][PLIC_PRIO_WIDTH-1:0]  regs_prio_th_o,
    output logic [PLIC_SOURCE_COUNT-1:0]                       regs_trig_o,
    output logic [PLIC_TARGET_COUNT-1:0]                       claim_req_o,
    output logic [PLIC_TARGET_COUNT-1:0]                       complete_req_o,
    output logic [PLIC_TARGET_COUNT-1:0][SRC_W-1:0]            complete_idx_o
);
    localparam int N     = PLIC_SOURCE_COUNT;
    localparam int T     = PLIC_TARGET_COUNT;
    localparam int P     = PLIC_PRIO_WIDTH;
    localparam int PAD_W = IE_WORDS * 32;

    typedef enum logic {IDLE, ACK} state_e;
    state_e state, state_nxt;
    logic   accept, wr;

    logic [N-1:0][P-1:0] prio_q;
    logic [T-1:0][N-1:0] ie_q;
    logic [T-1:0][P-1:0] th_q;
    logic [XLEN-1:0]     r_data_q, rd_val;

    logic [PLIC_REG_OFFSET_WIDTH-1:0] off;
    logic [9:0]       word_idx;
    logic [4:0]       en_t, en_w, ctx_t;
    logic [SRC_W-1:0] cpl_id;
    logic             in_low, in_ctx;
    logic             sel_prio, sel_pend, sel_en, sel_trig, sel_th, sel_cc;
    logic [PAD_W-1:0] pend_pad;
    logic             unused_bits;

    assign off      = dbus2plic_i.addr[PLIC_REG_OFFSET_WIDTH-1:0];
    assign word_idx = off[11:2];
    assign en_t     = off[11:7];
    assign en_w     = off[6:2];
    assign ctx_t    = off[16:12];
    assign cpl_id   = dbus2plic_i.w_data[SRC_W-1:0];
    assign in_low   = (off[21:14] == '0);
    assign in_ctx   = off[21] && (off[20:17] == '0) && (int'(ctx_t) < T);
    assign sel_prio = in_low && (off[13:12] == 2'd0);
    assign sel_pend = in_low && (off[13:12] == 2'd1) && (int'(word_idx) < IE_WORDS);
    assign sel_en   = in_low && (off[13:12] == 2'd2) && (int'(en_t) < T) && (int'(en_w) < IE_WORDS);
    assign sel_th   = in_ctx && (word_idx == 10'd0);
    assign sel_cc   = in_ctx && (word_idx == 10'd1);
    assign wr       = accept && dbus2plic_i.w_en;
    // Bit b of word w maps to source 32w+b, so source 0 sits in a constant-zero slot
    assign pend_pad = PAD_W'({irq_pending_i, 1'b0});
    assign unused_bits = ^{dbus2plic_i.addr[XLEN-1:PLIC_REG_OFFSET_WIDTH],
                           dbus2plic_i.addr[1:0], dbus2plic_i.w_data};

`ifdef PLIC_TRIG_CFG_EN
    logic [N-1:0] trig_q;
    assign sel_trig    = in_low && (off[13:12] == 2'd3) && (int'(word_idx) < IE_WORDS);
    assign regs_trig_o = trig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= '0;
        end else if (wr && sel_trig) begin
            for (int k = 1; k <= N; k++)
                if (int'(word_idx) == k / 32)
                    trig_q[k-1] <= dbus2plic_i.w_data[k % 32];
        end
    end
`else
    logic [N-1:0] trig_q;
    assign sel_trig    = 1'b0;
    assign trig_q      = '0;
    assign regs_trig_o = '0;
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (rst_n && dbus2plic_i.req && plic_sel_i) begin
                accept    = 1'b1;
                state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (sel_prio)
            for (int k = 1; k <= N; k++)
                if (int'(word_idx) == k) rd_val = XLEN'(prio_q[k-1]);
        if (sel_pend)
            for (int w = 0; w < IE_WORDS; w++)
                if (int'(word_idx) == w) rd_val = XLEN'(pend_pad >> (32 * w));
        if (sel_en)
            for (int t = 0; t < T; t++)
                for (int w = 0; w < IE_WORDS; w++)
                    if (int'(en_t) == t && int'(en_w) == w)
                        rd_val = XLEN'(PAD_W'({ie_q[t], 1'b0}) >> (32 * w));
        if (sel_trig)
            for (int w = 0; w < IE_WORDS; w++)
                if (int'(word_idx) == w) rd_val = XLEN'(PAD_W'({trig_q, 1'b0}) >> (32 * w));
        for (int t = 0; t < T; t++) begin
            if (sel_th && int'(ctx_t) == t) rd_val = XLEN'(th_q[t]);
            if (sel_cc && int'(ctx_t) == t) rd_val = XLEN'(claim_idx_i[t]);
        end
    end

    // Claim/complete pulses are combinational in the acceptance cycle only
    always_comb begin
        claim_req_o    = '0;
        complete_req_o = '0;
        complete_idx_o = '0;
        for (int t = 0; t < T; t++) begin
            if (accept && sel_cc && int'(ctx_t) == t) begin
                if (!dbus2plic_i.w_en) begin
                    claim_req_o[t] = 1'b1;
                end else begin
                    for (int k = 1; k <= N; k++)
                        if (int'(cpl_id) == k && ie_q[t][k-1]) begin
                            complete_req_o[t] = 1'b1;
                            complete_idx_o[t] = cpl_id;
                        end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            r_data_q <= '0;
            prio_q   <= '0;
            ie_q     <= '0;
            th_q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !dbus2plic_i.w_en)
                r_data_q <= rd_val;
            if (wr) begin
                for (int k = 1; k <= N; k++)
                    if (sel_prio && int'(word_idx) == k)
                        prio_q[k-1] <= dbus2plic_i.w_data[P-1:0];
                for (int t = 0; t < T; t++) begin
                    if (sel_th && int'(ctx_t) == t)
                        th_q[t] <= dbus2plic_i.w_data[P-1:0];
                    for (int k = 1; k <= N; k++)
                        if (sel_en && int'(en_t) == t && int'(en_w) == k / 32)
                            ie_q[t][k-1] <= dbus2plic_i.w_data[k % 32];
                end
            end
        end
    end

    assign plic2dbus_o.r_data = r_data_q;
    assign plic2dbus_o.ack    = (state == ACK);
    assign regs_prio_o        = prio_q;
    assign regs_ie_o          = ie_q;
    assign regs_prio_th_o     = th_q;

endmodule
